// File: rtl/shift_count_register.sv
// shift_count_register: WIDTH-bit accumulator/operand register with clear, load,
// inc/dec, 1-bit shifts and a multi-cycle shift-by-N command (busy/done handshake).
// Carry reports overflow/borrow/last bit shifted out; zero tracks out == 0.
// Optional build macro REG_SATURATE_EN: inc/dec saturate instead of wrapping.
module shift_count_register #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cl,
    input  logic               ld,
    input  logic               inc,
    input  logic               dec,
    input  logic               sr,
    input  logic               ir,
    input  logic               sl,
    input  logic               il,
    input  logic [WIDTH-1:0]   in,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    output logic [WIDTH-1:0]   out,
    output logic               carry,
    output logic               zero,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   shamt_clamped;
    logic               all_ones;
    logic               all_zero;

    // Shift amounts beyond the register width collapse to a full-width shift.
    always_comb begin
        if (32'(shamt) > 32'(WIDTH)) begin
            shamt_clamped = CNT_W'(WIDTH);
        end else begin
            shamt_clamped = CNT_W'(shamt);
        end
    end

    assign all_ones = &out_q;
    assign all_zero = ~|out_q;

    // Next-state and datapath: prioritised single op in IDLE, one bit per edge in SHIFT.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                end else if (ld) begin
                    out_d   = in;
                    carry_d = 1'b0;
                end else if (start) begin
                    if (shamt_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = shamt_clamped;
                        dir_d   = dir;
                        fill_d  = dir ? il : ir;
                    end
                end else if (inc) begin
                    carry_d = all_ones;
`ifdef REG_SATURATE_EN
                    if (!all_ones) out_d = out_q + WIDTH'(1);
`else
                    out_d = out_q + WIDTH'(1);
`endif
                end else if (dec) begin
                    carry_d = all_zero;
`ifdef REG_SATURATE_EN
                    if (!all_zero) out_d = out_q - WIDTH'(1);
`else
                    out_d = out_q - WIDTH'(1);
`endif
                end else if (sr) begin
                    out_d   = {ir, out_q[WIDTH-1:1]};
                    carry_d = out_q[0];
                end else if (sl) begin
                    out_d   = {out_q[WIDTH-2:0], il};
                    carry_d = out_q[WIDTH-1];
                end
            end
            SHIFT: begin
                if (cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (dir_q) begin
                        out_d   = {out_q[WIDTH-2:0], fill_q};
                        carry_d = out_q[WIDTH-1];
                    end else begin
                        out_d   = {fill_q, out_q[WIDTH-1:1]};
                        carry_d = out_q[0];
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any shift in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            dir_q   <= dir_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign done  = done_q;
    assign busy  = (state_q == SHIFT);
    assign zero  = (out_q == '0);

endmodule

// File: tb/tb_shift_count_register.sv
// Self-checking bench for shift_count_register (WIDTH=4, SHAMT_W=3): directed
// scenarios with literal expectations, then randomized stimulus against an
// arithmetic model of the register. Honours REG_SATURATE_EN like the design.
module tb_shift_count_register;

    localparam int W    = 4;
    localparam int SW   = 3;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cl = 0, ld = 0, inc = 0, dec = 0, sr = 0, ir = 0, sl = 0, il = 0;
    logic [W-1:0]  in_d = '0;
    logic          start = 0;
    logic [SW-1:0] shamt_d = '0;
    logic          dir_d = 0;
    logic [W-1:0]  out;
    logic          carry, zero, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: value, carry, remaining shift steps, pending done.
    int m_out = 0, m_carry = 0, rem = 0, m_done = 0, m_fill = 0, m_dir = 0;

    shift_count_register #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .sr(sr), .ir(ir), .sl(sl), .il(il), .in(in_d), .start(start),
        .shamt(shamt_d), .dir(dir_d), .out(out), .carry(carry), .zero(zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_carry = 0; rem = 0; m_done = 0;
    endtask

    task automatic model_step();
        int k;
        m_done = 0;
        if (rem > 0) begin
            if (cl) begin
                m_out = 0; m_carry = 0; rem = 0;
            end else begin
                if (m_dir != 0) begin
                    m_carry = m_out / HALF;
                    m_out   = (m_out * 2) % MOD + m_fill;
                end else begin
                    m_carry = m_out % 2;
                    m_out   = m_out / 2 + m_fill * HALF;
                end
                rem--;
                if (rem == 0) m_done = 1;
            end
        end else if (cl) begin
            m_out = 0; m_carry = 0;
        end else if (ld) begin
            m_out = int'(in_d); m_carry = 0;
        end else if (start) begin
            k = int'(shamt_d);
            if (k > W) k = W;
            if (k == 0) m_done = 1;
            else begin
                rem = k; m_dir = int'(dir_d); m_fill = dir_d ? int'(il) : int'(ir);
            end
        end else if (inc) begin
            m_carry = (m_out == MOD - 1) ? 1 : 0;
`ifdef REG_SATURATE_EN
            if (m_out != MOD - 1) m_out = m_out + 1;
`else
            m_out = (m_out + 1) % MOD;
`endif
        end else if (dec) begin
            m_carry = (m_out == 0) ? 1 : 0;
`ifdef REG_SATURATE_EN
            if (m_out != 0) m_out = m_out - 1;
`else
            m_out = (m_out + MOD - 1) % MOD;
`endif
        end else if (sr) begin
            m_carry = m_out % 2;
            m_out   = m_out / 2 + int'(ir) * HALF;
        end else if (sl) begin
            m_carry = m_out / HALF;
            m_out   = (m_out * 2) % MOD + int'(il);
        end
    endtask

    task automatic idle_inputs();
        cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0; start = 0;
    endtask

    // One clock edge: model follows the same inputs, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic load(input int v);
        idle_inputs(); ld = 1; in_d = W'(v);
        tick();
        idle_inputs();
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        chk("cyc_out",   int'(out),   m_out);
        chk("cyc_carry", int'(carry), m_carry);
        chk("cyc_zero",  int'(zero),  (m_out == 0) ? 1 : 0);
        chk("cyc_busy",  int'(busy),  (rem > 0) ? 1 : 0);
        chk("cyc_done",  int'(done),  m_done);
    end

    initial begin
        // Reset state
        model_reset();
        #3;
        chk("rst_out", int'(out), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_zero", int'(zero), 1);
        rst_n = 1;
        @(posedge clk); #2;

        // 1: load 1011 then five increments
        load(11);
        chk("t1_ld", int'(out), 11);
        inc = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
`ifdef REG_SATURATE_EN
            chk("t1_out", int'(out), (12 + i > 15) ? 15 : 12 + i);
`else
            chk("t1_out", int'(out), (12 + i) % 16);
`endif
            chk("t1_carry", int'(carry), (i == 4) ? 1 : 0);
        end
`ifndef REG_SATURATE_EN
        chk("t1_zero", int'(zero), 1);
`endif
        idle_inputs();

        // 2: ld beats inc on the same edge
        load(7);
        ld = 1; inc = 1; in_d = 4'b0011;
        tick();
        chk("t2_out", int'(out), 3);
        chk("t2_carry", int'(carry), 0);
        idle_inputs();

        // 3: shift right by 2 filling ones
        load(6);
        start = 1; shamt_d = 3'd2; dir_d = 0; ir = 1;
        tick();
        idle_inputs(); ir = 0;
        chk("t3_busy0", int'(busy), 1);
        chk("t3_out0", int'(out), 6);
        tick();
        chk("t3_out1", int'(out), 11);
        chk("t3_busy1", int'(busy), 1);
        tick();
        chk("t3_out2", int'(out), 13);
        chk("t3_carry", int'(carry), 1);
        chk("t3_busy2", int'(busy), 0);
        chk("t3_done", int'(done), 1);
        tick();
        chk("t3_done_clr", int'(done), 0);

        // 4: shamt 7 clamps to 4 on a left shift of 0001
        load(1);
        start = 1; shamt_d = 3'd7; dir_d = 1; il = 0;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            chk("t4_busy", int'(busy), 1);
            tick();
        end
        chk("t4_out", int'(out), 0);
        chk("t4_carry", int'(carry), 1);
        chk("t4_zero", int'(zero), 1);
        chk("t4_busy_end", int'(busy), 0);
        chk("t4_done", int'(done), 1);

        // 5: clear aborts a shift; async reset aborts another
        load(15);
        start = 1; shamt_d = 3'd3; dir_d = 0; ir = 0;
        tick();
        idle_inputs();
        tick();
        chk("t5_shift1", int'(out), 7);
        cl = 1;
        tick();
        cl = 0;
        chk("t5_cl_out", int'(out), 0);
        chk("t5_cl_busy", int'(busy), 0);
        chk("t5_cl_done", int'(done), 0);
        tick();
        chk("t5_no_done", int'(done), 0);
        load(15);
        start = 1; shamt_d = 3'd3;
        tick();
        idle_inputs();
        tick();
        rst_n = 0; model_reset();
        #1;
        chk("t5_rst_out", int'(out), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_carry", int'(carry), 0);
        chk("t5_rst_done", int'(done), 0);
        #1 rst_n = 1;
        tick();

        // 6: wrap or saturate at the extremes
        load(15);
        inc = 1;
        tick();
        idle_inputs();
`ifdef REG_SATURATE_EN
        chk("t6_inc", int'(out), 15);
`else
        chk("t6_inc", int'(out), 0);
`endif
        chk("t6_inc_c", int'(carry), 1);
        load(0);
        dec = 1;
        tick();
        idle_inputs();
`ifdef REG_SATURATE_EN
        chk("t6_dec", int'(out), 0);
`else
        chk("t6_dec", int'(out), 15);
`endif
        chk("t6_dec_c", int'(carry), 1);

        // start with shamt 0: done pulse, no busy, no data change
        load(9);
        start = 1; shamt_d = 3'd0;
        tick();
        idle_inputs();
        chk("z_out", int'(out), 9);
        chk("z_busy", int'(busy), 0);
        chk("z_done", int'(done), 1);

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            cl      = ($urandom_range(0, 29) == 0);
            ld      = ($urandom_range(0, 5) == 0);
            start   = ($urandom_range(0, 4) == 0);
            inc     = 1'($urandom);
            dec     = 1'($urandom);
            sr      = 1'($urandom);
            sl      = 1'($urandom);
            ir      = 1'($urandom);
            il      = 1'($urandom);
            dir_d   = 1'($urandom);
            in_d    = W'($urandom);
            shamt_d = SW'($urandom);
            if (i % 211 == 150) begin
                rst_n = 0; model_reset();
                #1;
                chk("rnd_rst_out", int'(out), 0);
                chk("rnd_rst_busy", int'(busy), 0);
                #1 rst_n = 1;
            end
            tick();
        end

        idle_inputs();
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
